// File: rtl/b8to3_pending_encoder_pkg.sv
// Shared constants and FSM state encoding for the pending-request 8-to-3 encoder.
package b8to3_pending_encoder_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_e;

endpackage : b8to3_pending_encoder_pkg

// File: rtl/b8to3_pri_encoder.sv
// Combinational 8-to-3 priority encoder, highest set bit wins; zero latency.
// No handshake: code is 0 and nz is low when the input vector is empty.
module b8to3_pri_encoder
  import b8to3_pending_encoder_pkg::*;
(
  input  logic [N_REQ-1:0]  vec,
  output logic [CODE_W-1:0] code,
  output logic              nz
);

  // Ascending scan so the last assignment, the highest index, wins.
  always_comb begin
    code = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) begin
        code = CODE_W'(i);
      end
    end
  end

  assign nz = |vec;

endmodule : b8to3_pri_encoder

// File: rtl/b8to3_pending_encoder.sv
// Pending-request register feeding a registered priority encoder; a code is valid one edge after its request is pending.
// valid/ready output: code and valid are held while rdy=0; one accept per cycle with no bubble between codes.
module b8to3_pending_encoder
  import b8to3_pending_encoder_pkg::*;
(
  input  logic              clock,
  input  logic              reset_,
  input  logic [N_REQ-1:0]  x7_x0,
  input  logic              e,
  input  logic              rdy,
  output logic [CODE_W-1:0] z2_z0,
  output logic              v,
  output logic [N_REQ-1:0]  p7_p0,
  output logic              ovf
);

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    p_q, p_d;
  logic [CODE_W-1:0]   z_q, z_d;
  logic                ovf_q, ovf_d;

  logic                accept;
  logic [N_REQ-1:0]    clr_mask;
  logic [N_REQ-1:0]    set_vec;
  logic [N_REQ-1:0]    r_vec;
  logic [CODE_W-1:0]   p_code, r_code;
  logic                p_nz, r_nz;

  assign accept  = (state_q == S_OFFER) && rdy;
  assign set_vec = e ? x7_x0 : '0;

  // 3-to-8 decode of the offered code, enabled only by an accept.
  always_comb begin
    clr_mask = '0;
    if (accept) begin
      clr_mask[z_q] = 1'b1;
    end
  end

  // r excludes same-edge arrivals, so a re-set of the accepted bit is offered later.
  assign r_vec = p_q & ~clr_mask;

  b8to3_pri_encoder u_enc_p (
    .vec  (p_q),
    .code (p_code),
    .nz   (p_nz)
  );

  b8to3_pri_encoder u_enc_r (
    .vec  (r_vec),
    .code (r_code),
    .nz   (r_nz)
  );

  always_comb begin
    p_d   = r_vec | set_vec;
    ovf_d = ovf_q | (|(set_vec & r_vec));
  end

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    case (state_q)
      S_IDLE: begin
        if (p_nz) begin
          state_d = S_OFFER;
          z_d     = p_code;
        end
      end
      S_OFFER: begin
        if (accept) begin
          if (r_nz) begin
            z_d = r_code;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      z_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      z_q     <= z_d;
      ovf_q   <= ovf_d;
    end
  end

  assign z2_z0 = z_q;
  assign v     = (state_q == S_OFFER);
  assign p7_p0 = p_q;
  assign ovf   = ovf_q;

endmodule : b8to3_pending_encoder
